// File: rtl/saradc_ctrl.sv
// saradc_ctrl -- successive-approximation sequencer for the on-chip SAR ADC.
//
// A conversion is a track phase of SAMPLE_CYCLES cycles, then NBITS bit
// trials (MSB first), then a single DONE cycle. DONE strobes `valid` and
// holds the new `result`. In continuous mode, DONE goes straight back into
// the track phase.
//
// Ports
//   clk      conversion clock
//   rst      synchronous reset, active low
//   go       start request, level-sampled in IDLE and DONE
//   cont     continuous mode, sampled only in DONE
//   cmp      comparator decision (1 = input >= DAC), synchronous to clk
//   sample   track/hold control, 1 = track
//   dac_code trial code driven to the capacitive DAC
//   result   last completed conversion, held until the next DONE
//   valid    one-cycle strobe when result updates
//   busy     high in SAMPLE, CONV and DONE
//
// Every output is a register. No output depends combinationally on go,
// cont or cmp.
module saradc_ctrl #(
  parameter int NBITS         = 5,
  parameter int SAMPLE_CYCLES = 2   // legal range 1..15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic             cont,
  input  logic             cmp,
  output logic             sample,
  output logic [NBITS-1:0] dac_code,
  output logic [NBITS-1:0] result,
  output logic             valid,
  output logic             busy
);

  localparam int         IW      = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam logic [3:0] SC_LOAD = 4'(SAMPLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SAMPLE = 2'd1,
    CONV   = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t           state;
  logic [IW-1:0]    idx;       // bit currently under trial
  logic [3:0]       scnt;      // remaining track cycles minus one
  logic [NBITS-1:0] acc;       // bits accepted so far
  logic [NBITS-1:0] bit_mask;
  logic [NBITS-1:0] acc_nxt;

  assign bit_mask = NBITS'(1) << idx;
  // Keep the trial bit when the comparator reports input >= DAC.
  assign acc_nxt  = cmp ? (acc | bit_mask) : acc;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      idx      <= IW'(NBITS - 1);
      scnt     <= '0;
      acc      <= '0;
      sample   <= 1'b0;
      dac_code <= '0;
      result   <= '0;
      valid    <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (go) begin
            state  <= SAMPLE;
            scnt   <= SC_LOAD;
            sample <= 1'b1;
            busy   <= 1'b1;
          end
        end
        SAMPLE: begin
          if (scnt == '0) begin
            // Leave track mode and present the MSB trial in the next cycle.
            state    <= CONV;
            sample   <= 1'b0;
            idx      <= IW'(NBITS - 1);
            acc      <= '0;
            dac_code <= NBITS'(1) << (NBITS - 1);
          end else begin
            scnt <= scnt - 4'd1;
          end
        end
        CONV: begin
          acc <= acc_nxt;
          if (idx == '0) begin
            state    <= DONE;
            result   <= acc_nxt;
            valid    <= 1'b1;
            dac_code <= '0;
          end else begin
            idx      <= idx - IW'(1);
            // Next trial: the accepted bits plus the next lower bit.
            dac_code <= acc_nxt | (bit_mask >> 1);
          end
        end
        DONE: begin
          valid <= 1'b0;
          if (cont || go) begin
            state  <= SAMPLE;
            scnt   <= SC_LOAD;
            sample <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_saradc_ctrl.sv
// Self-checking bench for saradc_ctrl.
// The reference model tracks only "cycles since the start of the current
// conversion" (t). All expected outputs are derived from t with plain
// arithmetic. An ideal comparator, cmp = (vin >= dac_code), closes the loop.
module tb_saradc_ctrl;
  localparam int N  = 5;
  localparam int SC = 2;
  localparam int L  = SC + N + 1;  // t of the DONE cycle

  logic         clk, rst, go, cont, cmp;
  logic         sample, valid, busy;
  logic [N-1:0] dac_code, result;
  logic [N-1:0] vin;

  int n_chk, n_err;
  int t, m_res;

  saradc_ctrl #(.NBITS(N), .SAMPLE_CYCLES(SC)) dut (
    .clk(clk), .rst(rst), .go(go), .cont(cont), .cmp(cmp),
    .sample(sample), .dac_code(dac_code), .result(result),
    .valid(valid), .busy(busy)
  );

  assign cmp = (vin >= dac_code);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0d, time %0t)", tag, act, exp, t, $time);
    end
  endtask

  // Ideal SAR trial code at conversion cycle tt: the bits of v above the
  // trial position, plus the trial bit itself.
  function automatic int exp_dac(input int tt, input int v);
    int p;
    if (tt <= SC || tt > SC + N) return 0;
    p = N - 1 - (tt - SC - 1);
    return ((v >> (p + 1)) << (p + 1)) | (1 << p);
  endfunction

  // One clock edge. The model advances on the inputs set before the edge,
  // then all outputs are compared 1 ns later.
  task automatic tick();
    @(posedge clk);
    if (!rst) begin
      t = 0;
      m_res = 0;
    end else if (t == 0) begin
      t = go ? 1 : 0;
    end else if (t == L) begin
      t = (cont || go) ? 1 : 0;
    end else begin
      t = t + 1;
      if (t == L) m_res = int'(vin);
    end
    #1;
    chk("m_sample", int'(sample),   int'(t >= 1 && t <= SC));
    chk("m_dac",    int'(dac_code), exp_dac(t, int'(vin)));
    chk("m_result", int'(result),   m_res);
    chk("m_valid",  int'(valid),    int'(t == L));
    chk("m_busy",   int'(busy),     int'(t != 0));
  endtask

  task automatic conv_dir(input int v, input int e0, input int e1, input int e2,
                          input int e3, input int e4);
    int ex[5];
    ex = '{e0, e1, e2, e3, e4};
    vin = N'(v);
    go  = 1'b1;
    tick();
    go  = 1'b0;
    chk("d_samp1", int'(sample), 1);
    for (int c = 2; c <= 9; c++) begin
      tick();
      if (c == 2) chk("d_samp2", int'(sample), 1);
      if (c >= 3 && c <= 7) chk("d_trial", int'(dac_code), ex[c-3]);
      if (c == 8) begin
        chk("d_valid8", int'(valid), 1);
        chk("d_res8", int'(result), v);
      end
      if (c == 7 || c == 9) chk("d_valid_off", int'(valid), 0);
      if (c == 9) chk("d_busy9", int'(busy), 0);
    end
  endtask

  task automatic cont_run(input int clear_at, input int last);
    cont = 1'b1;
    vin  = 5'd5;
    go   = 1'b1;
    tick();
    go   = 1'b0;
    vin  = 5'd26;  // changes during the first SAMPLE phase
    for (int c = 2; c <= last + 2; c++) begin
      tick();
      if (c % 8 == 0 && c <= last) begin
        chk("c_valid", int'(valid), 1);
        chk("c_result", int'(result), 26);
      end
      if (c == last + 1) chk("c_idle", int'(busy), 0);
      if (c == clear_at) cont = 1'b0;
    end
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    t     = 0;
    m_res = 0;
    rst   = 1'b0;
    go    = 1'b1;
    cont  = 1'b0;
    vin   = '0;

    // Reset is held with go high: everything stays zero.
    repeat (3) begin
      tick();
      chk("r_busy", int'(busy), 0);
      chk("r_sample", int'(sample), 0);
      chk("r_result", int'(result), 0);
    end
    rst = 1'b1;
    tick();
    chk("r_start", int'(sample), 1);
    go = 1'b0;
    repeat (10) tick();

    // Directed conversions.
    conv_dir(19, 16, 24, 20, 18, 19);
    conv_dir(31, 16, 24, 28, 30, 31);
    conv_dir(0,  16, 8,  4,  2,  1);

    // Continuous mode: clear cont late, then clear it early.
    cont_run(20, 24);
    cont_run(10, 16);

    // go pulses during the conversion are ignored.
    begin
      int nv;
      nv  = 0;
      vin = N'($urandom_range(0, 31));
      go  = 1'b1;
      tick();
      go  = 1'b0;
      for (int c = 2; c <= 12; c++) begin
        tick();
        if (valid) nv++;
        go = (c == 3 || c == 6);
      end
      go = 1'b0;
      chk("g_nvalid", nv, 1);
      chk("g_idle", int'(busy), 0);
    end

    // Reset in the middle of a conversion.
    begin
      int nv;
      nv  = 0;
      vin = N'($urandom_range(0, 31));
      go  = 1'b1;
      tick();
      go  = 1'b0;
      repeat (4) tick();  // now in cycle 5
      rst = 1'b0;
      tick();
      chk("x_dac", int'(dac_code), 0);
      chk("x_result", int'(result), 0);
      chk("x_busy", int'(busy), 0);
      rst = 1'b1;
      repeat (10) begin
        tick();
        if (valid) nv++;
      end
      chk("x_novalid", nv, 0);
      vin = 5'd13;
      go  = 1'b1;
      tick();
      go  = 1'b0;
      repeat (7) tick();
      chk("x_valid8", int'(valid), 1);
      chk("x_res8", int'(result), 13);
    end

    // Randomized traffic against the model. vin stays stable while bit
    // trials are in progress.
    for (int i = 0; i < 600; i++) begin
      go   = ($urandom_range(0, 3) == 0);
      cont = ($urandom_range(0, 3) == 0);
      rst  = ($urandom_range(0, 60) != 0);
      if (!(t > SC && t < L)) vin = N'($urandom_range(0, 31));
      tick();
    end
    go   = 1'b0;
    cont = 1'b0;
    rst  = 1'b1;
    repeat (12) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
